// File: rtl/grid_copy_engine.sv
// rtl/grid_copy_engine.sv - streams an M x N grid from the init RAM into up to CHANNELS frame RAMs
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             any toggle while idle requests a run
//   abort             level, synchronous; cancels a run in progress
//   mode              0=COPY 1=CLEAR 2=FILL 3=INVERT, sampled at run start
//   ch_mask           per-channel write enable, sampled at run start
//   fill_val          FILL constant, sampled at run start
//   read_addr         init RAM address; read_val returns RD_LAT cycles later
//   write_addr/en/val destination write port, shared address/data, per-channel strobe
//   busy              run in progress
//   finish            last run completed normally; held until the next run starts
module grid_copy_engine #(
    parameter int P_PARAM_M = 5,
    parameter int P_PARAM_N = 5,
    parameter int WIDTH     = 12,
    parameter int DATA_W    = 1,
    parameter int CHANNELS  = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [CHANNELS-1:0]  ch_mask,
    input  logic [DATA_W-1:0]    fill_val,
    output logic [2*WIDTH-1:0]   read_addr,
    input  logic [DATA_W-1:0]    read_val,
    output logic [2*WIDTH-1:0]   write_addr,
    output logic [CHANNELS-1:0]  write_en,
    output logic [DATA_W-1:0]    write_val,
    output logic                 busy,
    output logic                 finish
);

    localparam int AW    = 2 * WIDTH;
    localparam int TOTAL = P_PARAM_M * P_PARAM_N;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  prev_start_q, prev_start_d;
    logic [1:0]            mode_q, mode_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]     fill_q, fill_d;
    logic [AW-1:0]         read_addr_q, read_addr_d;
    logic [AW-1:0]         write_addr_q, write_addr_d;
    logic [CHANNELS-1:0]   write_en_q, write_en_d;
    logic [DATA_W-1:0]     write_val_q, write_val_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;

    // Read-tracking pipeline: stage 0 takes the address issued this cycle, the
    // last stage lines up with the read_val returned for it.
    logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
    logic [AW-1:0]         pipe_addr_q [RD_LAT];
    logic [AW-1:0]         pipe_addr_d [RD_LAT];

    logic                  trigger;
    logic                  emerge_vld;
    logic [AW-1:0]         emerge_addr;

    assign trigger     = (start != prev_start_q);
    assign emerge_vld  = pipe_vld_q[RD_LAT-1];
    assign emerge_addr = pipe_addr_q[RD_LAT-1];

    always_comb begin
        state_d      = state_q;
        prev_start_d = start;
        mode_d       = mode_q;
        mask_d       = mask_q;
        fill_d       = fill_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        write_en_d   = '0;
        write_val_d  = write_val_q;
        busy_d       = busy_q;
        finish_d     = finish_q;

        pipe_vld_d[0]  = (state_q == S_ISSUE);
        pipe_addr_d[0] = read_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (trigger && !abort) begin
                    mode_d      = mode;
                    mask_d      = ch_mask;
                    fill_d      = fill_val;
                    read_addr_d = '0;
                    busy_d      = 1'b1;
                    finish_d    = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (read_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    read_addr_d = read_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
            end
            S_DONE: begin
                busy_d   = 1'b0;
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The write for an emerging entry is registered this cycle; once the
        // last cell goes out, DONE is the cycle in which it is visible.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && emerge_vld) begin
            write_addr_d = emerge_addr;
            write_en_d   = mask_q;
            case (mode_q)
                2'd0:    write_val_d = read_val;
                2'd1:    write_val_d = '0;
                2'd2:    write_val_d = fill_q;
                default: write_val_d = ~read_val;
            endcase
            if (emerge_addr == LAST_ADDR) begin
                state_d = S_DONE;
            end
        end

        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            write_en_d = '0;
            busy_d     = 1'b0;
            finish_d   = 1'b0;
            pipe_vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_start_q <= 1'b0;
            mode_q       <= '0;
            mask_q       <= '0;
            fill_q       <= '0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_en_q   <= '0;
            write_val_q  <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            pipe_vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            prev_start_q <= prev_start_d;
            mode_q       <= mode_d;
            mask_q       <= mask_d;
            fill_q       <= fill_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            write_en_q   <= write_en_d;
            write_val_q  <= write_val_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign read_addr  = read_addr_q;
    assign write_addr = write_addr_q;
    assign write_en   = write_en_q;
    assign write_val  = write_val_q;
    assign busy       = busy_q;
    assign finish     = finish_q;

endmodule

// File: tb/tb_grid_copy_engine.sv
// tb/tb_grid_copy_engine.sv - self-checking bench for grid_copy_engine (two configurations side by side)
module tb_grid_copy_engine;

    localparam int TOTAL = 25;
    localparam int AW    = 24;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [1:0]    mode;
    logic [3:0]    ch_mask;
    logic [3:0]    fill_val;

    logic [AW-1:0] ra_a, wa_a, ra_b, wa_b;
    logic          rv_a, wv_a;
    logic [3:0]    rv_b, wv_b;
    logic [3:0]    we_a, we_b;
    logic          busy_a, fin_a, busy_b, fin_b;

    logic          mem_a [TOTAL];
    logic [3:0]    mem_b [TOTAL];
    logic [3:0]    hist_b [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    grid_copy_engine #(.P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12), .DATA_W(1), .CHANNELS(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .ch_mask(ch_mask), .fill_val(fill_val[0]), .read_addr(ra_a), .read_val(rv_a),
        .write_addr(wa_a), .write_en(we_a), .write_val(wv_a), .busy(busy_a), .finish(fin_a)
    );

    grid_copy_engine #(.P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12), .DATA_W(4), .CHANNELS(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .ch_mask(ch_mask), .fill_val(fill_val), .read_addr(ra_b), .read_val(rv_b),
        .write_addr(wa_b), .write_en(we_b), .write_val(wv_b), .busy(busy_b), .finish(fin_b)
    );

    // Init RAM models: data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        rv_a      <= (ra_a < TOTAL) ? mem_a[ra_a[4:0]] : 1'b0;
        hist_b[0] <= (ra_b < TOTAL) ? mem_b[ra_b[4:0]] : 4'h0;
        hist_b[1] <= hist_b[0];
        hist_b[2] <= hist_b[1];
    end
    assign rv_b = hist_b[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_val(input logic [1:0] md, input logic [3:0] d,
                                           input logic [3:0] f, input int dw);
        logic [3:0] r;
        logic [3:0] m;
        m = 4'((1 << dw) - 1);
        case (md)
            2'd0:    r = d;
            2'd1:    r = 4'h0;
            2'd2:    r = f;
            default: r = ~d;
        endcase
        return r & m;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ra_a"}, ra_a, 0);   check({tag, "_ra_b"}, ra_b, 0);
        check({tag, "_wa_a"}, wa_a, 0);   check({tag, "_wa_b"}, wa_b, 0);
        check({tag, "_we_a"}, we_a, 0);   check({tag, "_we_b"}, we_b, 0);
        check({tag, "_wv_a"}, wv_a, 0);   check({tag, "_wv_b"}, wv_b, 0);
        check({tag, "_busy_a"}, busy_a, 0); check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_fin_a"}, fin_a, 0); check({tag, "_fin_b"}, fin_b, 0);
    endtask

    task automatic check_quiet(input string tag, input logic fin_exp);
        check({tag, "_we_a"}, we_a, 0);       check({tag, "_we_b"}, we_b, 0);
        check({tag, "_busy_a"}, busy_a, 0);   check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_fin_a"}, fin_a, fin_exp); check({tag, "_fin_b"}, fin_b, fin_exp);
    endtask

    // One run: toggle start, score every write of both DUTs against the
    // reference list (addr i, strobe = mask, data = mode applied to mem[i]).
    // Optional events keyed on dut_b's write count: extra toggle, abort, reset.
    task automatic run(input logic [1:0] md, input logic [3:0] mk, input logic [3:0] fv,
                       input int tog_at, input int abort_at, input int reset_at, input int post_idle);
        int na, nb, fa, fb, nexp;
        bit bok_a, bok_b, stopped, toggled;
        na = 0; nb = 0; fa = 0; fb = 0;
        bok_a = 1; bok_b = 1; stopped = 0; toggled = 0;
        nexp = (mk != 4'h0) ? TOTAL : 0;
        mode = md; ch_mask = mk; fill_val = fv;
        start = ~start;
        for (int cyc = 1; cyc <= 80 && !(fa != 0 && fb != 0) && !stopped; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                check("a_start_busy", busy_a, 1); check("a_start_fin", fin_a, 0);
                check("b_start_busy", busy_b, 1); check("b_start_fin", fin_b, 0);
            end
            if (fa == 0) begin
                if (fin_a) fa = cyc; else if (!busy_a) bok_a = 0;
            end
            if (fb == 0) begin
                if (fin_b) fb = cyc; else if (!busy_b) bok_b = 0;
            end
            if (we_a != 4'h0) begin
                check("a_addr", wa_a, na);
                check("a_en", we_a, mk);
                check("a_val", wv_a, ref_val(md, (na < TOTAL) ? {3'b0, mem_a[na]} : 4'h0, fv, 1));
                na++;
            end
            if (we_b != 4'h0) begin
                check("b_addr", wa_b, nb);
                check("b_en", we_b, mk);
                check("b_val", wv_b, ref_val(md, (nb < TOTAL) ? mem_b[nb] : 4'h0, fv, 4));
                nb++;
            end
            if (tog_at >= 0 && nb == tog_at && !toggled) begin
                start = ~start;
                toggled = 1;
            end
            if (abort_at >= 0 && nb == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check_quiet("abort", 1'b0);
                stopped = 1;
            end
            if (reset_at >= 0 && nb == reset_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check_zero("rst_mid");
                @(posedge clk); #1;
                check_zero("rst_hold");
                rst_n = 1'b1;
                stopped = 1;
            end
        end
        if (abort_at < 0 && reset_at < 0) begin
            check("a_finish_cycle", fa, TOTAL + 1 + 2);
            check("b_finish_cycle", fb, TOTAL + 3 + 2);
            check("a_nwrites", na, nexp);
            check("b_nwrites", nb, nexp);
            check("a_busy_run", bok_a, 1);
            check("b_busy_run", bok_b, 1);
            for (int k = 0; k < post_idle; k++) begin
                @(posedge clk); #1;
                check_quiet("post", 1'b1);
            end
        end else begin
            check("stop_reached", stopped, 1);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check_quiet("after_stop", 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        mode = 2'd0; ch_mask = 4'h0; fill_val = 4'h0;
        for (int i = 0; i < TOTAL; i++) begin
            mem_a[i] = (i % 3 == 0);
            mem_b[i] = 4'(i);
        end
        repeat (2) @(posedge clk); #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("idle");

        run(2'd0, 4'hF,    4'h0, -1, -1, -1, 2);   // COPY, patterned RAM
        run(2'd3, 4'b0101, 4'h0, -1, -1, -1, 2);   // INVERT, partial mask
        run(2'd2, 4'hF,    4'hA, -1, -1, -1, 1);   // FILL, then back-to-back CLEAR
        run(2'd1, 4'hF,    4'h0, -1, -1, -1, 2);
        run(2'd0, 4'hF,    4'h0, 10, -1, -1, 6);   // toggle while busy is ignored
        run(2'd3, 4'hB,    4'h0, -1,  7, -1, 0);   // abort at write 7
        run(2'd0, 4'hF,    4'h0, -1, -1, -1, 1);   // clean restart

        // Trigger and abort together in IDLE: abort wins, toggle is consumed.
        abort = 1'b1;
        start = ~start;
        @(posedge clk); #1;
        abort = 1'b0;
        check_quiet("idle_abort", 1'b1);
        @(posedge clk); #1;
        check_quiet("idle_abort2", 1'b1);

        run(2'd2, 4'h6,    4'h5, -1, -1, 12, 0);   // async reset at write 12
        run(2'd0, 4'hF,    4'h0, -1, -1, -1, 1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < TOTAL; i++) begin
                mem_a[i] = 1'($urandom);
                mem_b[i] = 4'($urandom);
            end
            run(2'($urandom_range(0, 3)),
                (r == 2) ? 4'h0 : 4'($urandom_range(1, 15)),
                4'($urandom), -1, -1, -1, r % 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
